// File: rtl/bus_unit_pkg.sv
// Shared types for the bus responder: command field enums, bus FSM states
// and the address/data widths used by the control-unit command interface.
package bus_unit_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {NOLOAD = 1'b0, LOAD = 1'b1} il_t;
  typedef enum logic {PC_ADDR = 1'b0, AR_ADDR = 1'b1} mm_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mw_t;
  typedef enum logic [1:0] {HOLD = 2'd0, INC = 2'd1, JUMP = 2'd2} ps_t;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} bus_state_t;
endpackage

// File: rtl/bus_unit_if.sv
// Command handshake from the control FSM plus the external memory bus,
// seen from the responder (slave) and from its environment (master).
interface bus_unit_if;
  import bus_unit_pkg::*;

  logic  cmd_valid;
  il_t   il;
  mm_t   mm;
  mw_t   mw;
  ps_t   ps;
  addr_t ar_in;
  data_t wdata;
  logic  busy;
  logic  done;
  logic  err;

  addr_t mem_addr;
  data_t mem_wdata;
  logic  mem_we;
  logic  mem_req;
  logic  mem_ack;
  data_t mem_rdata;

  modport slave (
    input  cmd_valid, il, mm, mw, ps, ar_in, wdata, mem_ack, mem_rdata,
    output busy, done, err, mem_addr, mem_wdata, mem_we, mem_req
  );

  modport master (
    output cmd_valid, il, mm, mw, ps, ar_in, wdata, mem_ack, mem_rdata,
    input  busy, done, err, mem_addr, mem_wdata, mem_we, mem_req
  );
endinterface

// File: rtl/bus_unit_pc_reg.sv
// Program counter with hold / increment / load; load has priority over inc.
// Increment wraps naturally at the top of the address space.
module pc_reg
  import bus_unit_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load,
  input  addr_t load_val,
  output addr_t pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + addr_t'(1);
    end
  end

endmodule

// File: rtl/bus_unit.sv
// Responder for control-unit bus commands: runs one req/ack memory transaction
// per accepted command, owns PC and IR, and reports busy/done/err.
module bus_unit
  import bus_unit_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0000,
  parameter int    MAX_WAIT = 15
) (
  input  logic  clk,
  input  logic  rst,
  bus_unit_if.slave bus,
  output addr_t pc,
  output data_t ir,
  output data_t rdata
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  bus_state_t state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;

  addr_t addr_q, addr_nxt;
  data_t wdata_q, wdata_nxt;
  logic  we_q, we_nxt;
  logic  req_q, req_nxt;
  logic  done_q, done_nxt;
  logic  err_q, err_nxt;
  data_t ir_nxt, rdata_nxt;

  il_t   lat_il, lat_il_nxt;
  mw_t   lat_mw, lat_mw_nxt;
  ps_t   lat_ps, lat_ps_nxt;
  addr_t lat_ar, lat_ar_nxt;

  logic pc_inc, pc_load;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (lat_ar),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ir       <= '0;
      rdata    <= '0;
      lat_il   <= NOLOAD;
      lat_mw   <= READ;
      lat_ps   <= HOLD;
      lat_ar   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      we_q     <= we_nxt;
      req_q    <= req_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      ir       <= ir_nxt;
      rdata    <= rdata_nxt;
      lat_il   <= lat_il_nxt;
      lat_mw   <= lat_mw_nxt;
      lat_ps   <= lat_ps_nxt;
      lat_ar   <= lat_ar_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = wait_cnt;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    we_nxt     = we_q;
    req_nxt    = req_q;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    ir_nxt     = ir;
    rdata_nxt  = rdata;
    lat_il_nxt = lat_il;
    lat_mw_nxt = lat_mw;
    lat_ps_nxt = lat_ps;
    lat_ar_nxt = lat_ar;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;

    case (state)
      IDLE: begin
        // mem_ack here is deliberately ignored
        if (bus.cmd_valid) begin
          lat_il_nxt = bus.il;
          lat_mw_nxt = bus.mw;
          lat_ps_nxt = bus.ps;
          lat_ar_nxt = bus.ar_in;
          case (bus.mm)
            AR_ADDR: addr_nxt = bus.ar_in;
            default: addr_nxt = pc;
          endcase
          we_nxt    = (bus.mw == WRITE);
          wdata_nxt = bus.wdata;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Ack is tested first so an ack on the final wait cycle still completes
        if (bus.mem_ack) begin
          if (lat_mw == READ) begin
            rdata_nxt = bus.mem_rdata;
            if (lat_il == LOAD) ir_nxt = bus.mem_rdata;
          end
          case (lat_ps)
            INC:     pc_inc  = 1'b1;
            JUMP:    pc_load = 1'b1;
            default: ;
          endcase
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = (state == REQ);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_req   = req_q;

endmodule

// File: doc/bus_unit.md
Name: bus_unit

Overview:
- Responder side of the control-unit command interface.
- Accepts one bus command per transaction, carried by the control fields il/mm/mw/ps.
- Drives the external memory bus with a req/ack handshake and tolerates wait states. Owns the program counter and the instruction register.
- Reports busy/done/err back to the control FSM so it can stall between INF/EX0 states.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles mem_req may stay high without mem_ack before the transaction is aborted.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  control presents a command this cycle
- il  in  il_t  LOAD: capture read data into IR; NOLOAD: no capture
- mm  in  mm_t  PC_ADDR: address from PC; AR_ADDR: address from ar_in
- mw  in  mw_t  READ / WRITE
- ps  in  ps_t  HOLD / INC (PC+1) / JUMP (PC<=ar_in)
- ar_in  in  16  datapath address register
- wdata  in  8  store data
- busy  out  1  transaction in progress; command not accepted
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on timeout abort
- pc  out  16  program counter
- ir  out  data_t  instruction register
- rdata  out  8  last read data
- mem_addr  out  16  bus address
- mem_wdata  out  8  bus write data
- mem_we  out  1  bus write strobe, valid while mem_req
- mem_req  out  1  bus request
- mem_ack  in  1  bus acknowledge; read data valid the same cycle

Behaviour:
- Reset values: pc=RESET_PC; ir=0; rdata=0; mem_addr=0; mem_wdata=0; mem_we=0; mem_req=0; busy=0; done=0; err=0; state IDLE; wait counter 0.
- Reset is asynchronous. Asserting rst mid-transaction drops mem_req immediately and discards the latched command.
- FSM states: IDLE, REQ.
- IDLE:
  - Accept when cmd_valid=1. Latch il, mw, ps and ar_in.
  - Set mem_addr = (mm==PC_ADDR) ? pc : ar_in; mem_we = (mw==WRITE); mem_wdata = wdata.
  - Set mem_req=1, clear the counter, go to REQ.
  - Registered outputs: mem_req rises the cycle after accept.
- REQ:
  - busy=1.
  - Bus outputs are held stable until completion.
  - cmd_valid is ignored.
- Completion (mem_ack=1 in REQ):
  - If READ: rdata <= mem_rdata. If also il==LOAD: ir <= mem_rdata.
  - A WRITE never changes ir or rdata.
  - ps==INC: pc <= pc+1, wrapping 16'hFFFF to 16'h0000.
  - ps==JUMP: pc <= latched ar_in.
  - ps==HOLD: pc unchanged.
  - mem_req=0 and mem_we=0 next cycle; done=1 for exactly one cycle; return to IDLE.
- Zero-wait memory: mem_ack in the first REQ cycle is legal.
  - Transaction = 1 accept cycle + 1 bus cycle.
  - done is high in the cycle after ack; a new command is accepted in that same cycle (busy=0).
- Timeout:
  - The counter increments each REQ cycle without ack.
  - When MAX_WAIT is reached, go to IDLE with mem_req=0 and err=1 for one cycle.
  - pc, ir and rdata are unchanged.
  - If ack coincides with the final count, ack wins: normal completion, no err.
- mem_ack while IDLE is ignored and has no side effects.
- Unused enum encodings (default case) are treated as a read from PC, no IR load, HOLD.
- done and err are never high in the same cycle.

Decomposition:
- common_types package: add AR_ADDR to mm_t and JUMP to ps_t.
- New bus_state_t enum {IDLE, REQ} in common_types.
- Address width constant ADDR_W=16 in common_types.
- One natural sub-module: pc_reg (16-bit PC with hold/inc/load and reset value parameter). The FSM and bus registers stay in bus_unit.

Test Plan:
- Reset: assert rst mid-REQ with RESET_PC=16'hC000 -> mem_req drops the same cycle, pc=16'hC000, ir=0, busy=0, no done/err.
- Fetch, zero-wait:
  - Setup: pc=16'h0200, command (LOAD, PC_ADDR, READ, INC), memory returns 8'hA9 with ack on the first REQ cycle.
  - Required: mem_addr=16'h0200, ir=8'hA9, pc=16'h0201, done one cycle, 2-cycle turnaround.
- Write with wait states:
  - Setup: (NOLOAD, AR_ADDR, WRITE, HOLD), ar_in=16'h1234, wdata=8'h55, ack after 3 cycles.
  - Required: mem_we=1, mem_wdata=8'h55, mem_addr held at 16'h1234 all 3 cycles, ir/rdata/pc unchanged, done once.
- PC wrap and jump:
  - pc=16'hFFFF, INC read -> pc=16'h0000.
  - Then JUMP with ar_in=16'h8000 -> pc=16'h8000.
- Timeout: MAX_WAIT=4, never ack -> err pulses once after 4 REQ cycles, mem_req=0, pc unchanged; the next command is accepted normally.
- Edge cases:
  - ack on the last timeout cycle -> done, no err.
  - ack while IDLE -> no state change.
  - cmd_valid held during REQ -> exactly one transaction per accept.
